// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// State enum plus a helper that turns a requester id into its one-hot handshake bit.
package mem_ctrl_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW storage: synchronous write, registered read (data one edge after addr).
// No flow control; caller qualifies writes and decides when rdata is meaningful.
module mem_array #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int MAW   = 3
) (
  input  logic           clk,
  input  logic           we,
  input  logic [MAW-1:0] addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one mem_array; one access per 3 cycles.
// Latency: req seen at edge N -> gnt in cycle N+1 -> ack in cycle N+2; losers just hold req.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      err,
  output logic            busy
);

  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state, state_nxt;
  logic            last;
  logic            win_id;
  logic            win_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_hold;
  logic [DW-1:0]   mem_rdata;
  logic            in_range;
  logic            mem_we;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win_id = (req == 2'b11) ? ~last : req[1];

  // Full address width is compared so high bits can never alias into the array.
  assign in_range = (32'(addr_q) < DEPTH);

  assign mem_we = (state == GRANT) && we_q && in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    ack       = 2'b00;
    err       = 2'b00;
    busy      = 1'b1;
    rdata     = rdata_hold;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt       = id2oh(win_q);
        state_nxt = RESP;
      end
      RESP: begin
        // A reset arriving in this cycle withdraws the completion.
        ack       = rst ? 2'b00 : id2oh(win_q);
        err       = (rst || in_range) ? 2'b00 : id2oh(win_q);
        state_nxt = IDLE;
        if (!in_range) begin
          rdata = '0;
        end else if (!we_q) begin
          rdata = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && |req) begin
      win_q   <= win_id;
      last    <= win_id;
      we_q    <= we[win_id];
      addr_q  <= win_id ? addr[2*AW-1:AW] : addr[AW-1:0];
      wdata_q <= win_id ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold <= '0;
    end else if (state == RESP) begin
      rdata_hold <= rdata;
    end
  end

  mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .MAW   (MAW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[MAW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of arbitration and storage.
// Directed scenarios first, then random traffic with late-arriving requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, gnt, ack, err;
  logic [15:0] addr, wdata;
  logic [7:0]  rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(8), .AW(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .err   (err),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Requester agents: a pending request is held until its grant is observed.
  bit         pend [2];
  bit         a_we [2];
  logic [7:0] a_addr [2];
  logic [7:0] a_wdata [2];

  // Reference model state.
  logic [7:0] mem_m [8];
  bit         mem_v [8];
  bit         last_m;
  logic [7:0] hold_m;
  bit         hold_ok;

  // Optional request injected during the next GRANT cycle.
  bit         late_vld;
  bit         late_id;
  bit         late_we;
  logic [7:0] late_addr, late_data;
  bit         rand_late;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive();
    req   = {pend[1], pend[0]};
    we    = {a_we[1], a_we[0]};
    addr  = {a_addr[1], a_addr[0]};
    wdata = {a_wdata[1], a_wdata[0]};
  endtask

  task automatic post(input bit i, input bit w, input logic [7:0] a, input logic [7:0] d);
    pend[i]    = 1'b1;
    a_we[i]    = w;
    a_addr[i]  = a;
    a_wdata[i] = d;
    drive();
  endtask

  task automatic rand_post(input bit i);
    int r;
    logic [7:0] a;
    r = int'($urandom_range(0, 11));
    if (r < 8)       a = 8'(r);
    else if (r < 10) a = 8'($urandom_range(8, 255));
    else             a = 8'h80 | 8'($urandom_range(0, 7));
    post(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    drive();
    last_m  = 1'b1;
    hold_m  = 8'h00;
    hold_ok = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; runs one full access (or one idle cycle).
  task automatic do_round();
    bit         w, ww, oor;
    logic [7:0] wa, wd;
    if (!pend[0] && !pend[1]) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
      return;
    end
    w  = (pend[0] && pend[1]) ? !last_m : pend[1];
    last_m = w;
    ww = a_we[w];
    wa = a_addr[w];
    wd = a_wdata[w];
    oor = (wa >= 8'd8);

    @(negedge clk);
    chk("gnt", gnt, 2'b01 << w);
    chk("busy_grant", busy, 1);
    chk("ack_grant", ack, 0);
    pend[w]    = 1'b0;
    a_we[w]    = 1'($urandom_range(0, 1));
    a_addr[w]  = 8'($urandom);
    a_wdata[w] = 8'($urandom);
    if (late_vld) begin
      post(late_id, late_we, late_addr, late_data);
      late_vld = 1'b0;
    end else if (rand_late) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) rand_post(1'(i));
    end
    drive();
    if (!oor && ww) begin
      mem_m[wa[2:0]] = wd;
      mem_v[wa[2:0]] = 1'b1;
    end

    @(negedge clk);
    chk("ack", ack, 2'b01 << w);
    chk("gnt_resp", gnt, 0);
    chk("err", err, oor ? (2'b01 << w) : 2'b00);
    if (oor) begin
      chk("rdata_oor", rdata, 0);
      hold_m = 8'h00;
      hold_ok = 1'b1;
    end else if (!ww && mem_v[wa[2:0]]) begin
      chk("rdata", rdata, mem_m[wa[2:0]]);
      hold_m = mem_m[wa[2:0]];
      hold_ok = 1'b1;
    end else begin
      hold_ok = 1'b0;
    end

    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ack_idle", ack, 0);
    chk("err_idle", err, 0);
    if (hold_ok) chk("rdata_hold", rdata, hold_m);
  endtask

  task automatic reset_in_grant();
    post(1'b0, 1'b1, 8'd5, 8'h3C);
    @(negedge clk);
    chk("rg_gnt", gnt, 2'b01);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rg_ack", ack, 0);
    chk("rg_busy", busy, 0);
    chk("rg_rdata", rdata, 0);
    rst = 1'b0;
  endtask

  initial begin
    late_vld  = 1'b0;
    rand_late = 1'b0;
    for (int i = 0; i < 8; i++) mem_v[i] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_we[i] = 1'b0; a_addr[i] = 8'h00; a_wdata[i] = 8'h00;
    end
    do_reset();

    // Single write then read back.
    post(1'b0, 1'b1, 8'd3, 8'hA5); do_round();
    post(1'b0, 1'b0, 8'd3, 8'h00); do_round();

    // Simultaneous requests straight after reset alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) post(1'(i), 1'b1, 8'(i + 1), 8'(8'h40 + k));
      do_round();
    end
    while (pend[0] || pend[1]) do_round();

    // Out-of-range accesses, including one whose low bits alias address 0.
    post(1'b0, 1'b1, 8'd0, 8'h11);  do_round();
    post(1'b1, 1'b1, 8'h08, 8'hFF); do_round();
    post(1'b1, 1'b1, 8'h88, 8'h77); do_round();
    post(1'b1, 1'b0, 8'd0, 8'h00);  do_round();
    post(1'b1, 1'b0, 8'h80, 8'h00); do_round();

    // Request raised while requester 0 is in GRANT is served next.
    late_vld = 1'b1; late_id = 1'b1; late_we = 1'b0; late_addr = 8'd3; late_data = 8'h00;
    post(1'b0, 1'b0, 8'd0, 8'h00); do_round();
    do_round();

    // Reset in the middle of a write leaves storage untouched.
    post(1'b0, 1'b1, 8'd5, 8'h11); do_round();
    reset_in_grant();
    post(1'b0, 1'b0, 8'd5, 8'h00); do_round();

    rand_late = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) rand_post(1'(i));
      do_round();
    end
    while (pend[0] || pend[1]) begin
      rand_late = 1'b0;
      do_round();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
